merge7_leaf_arbiter: RTL and testbench

- Clocked 2-to-1 merge leaf of the NoC tree, the return-direction counterpart of the 7-bit-address decoder leaf.
- Accepts 9-bit flit packets on two input channels and interleaves whole packets onto one output channel.
- Reports the winning input on a 1-bit side channel, S, which the decoder leaf would consume.
- Registered output stage gives full-throughput, full-buffer behaviour at the leaf boundary.

---
 rtl/merge7_pkg.sv | 28 ++
 rtl/merge7_out_reg.sv | 59 +++++
 rtl/merge7_leaf_arbiter.sv | 124 ++++++++++++
 tb/tb_merge7_leaf_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/merge7_pkg.sv
// merge7_pkg: shared definitions for the merge7 leaf arbiter and its
// output register.
//   FLIT_W   : flit width (tail flag in the MSB, payload below it)
//   TAIL_BIT : index of the tail flag
//   state_e  : arbiter FSM states (idle / locked to input 0 / locked to 1)
//   flit_t   : flit layout view (tail, payload)
//   sat_inc16: saturating 16-bit increment used by the optional counters
package merge7_pkg;

  localparam int FLIT_W   = 9;
  localparam int TAIL_BIT = FLIT_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  typedef struct packed {
    logic              tail;
    logic [FLIT_W-2:0] payload;
  } flit_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/merge7_out_reg.sv
// merge7_out_reg: one-entry valid/ready output register.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : capture data_i/src_i this cycle (only when load_ok_o)
//   data_i, src_i : flit and its source index
//   ready_i       : downstream accept
//   load_ok_o     : register is empty or draining this cycle
//   data_o, src_o, valid_o : registered flit, source index, valid
// Loading while draining keeps 1 flit/cycle throughput.
module merge7_out_reg #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         src_i,
  input  logic         ready_i,
  output logic         load_ok_o,
  output logic [W-1:0] data_o,
  output logic         src_o,
  output logic         valid_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         src_q, src_d;

  assign load_ok_o = ~valid_q | ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      src_d   = src_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign data_o  = data_q;
  assign src_o   = src_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/merge7_leaf_arbiter.sv
// merge7_leaf_arbiter: 2-to-1 packet-interleaving merge leaf.
//   CLK, _RESET          : clock, synchronous active-low reset
//   In0_*/In1_*          : input flit channels (data/valid/ready)
//   Out_data/Out_valid/Out_ready : registered merged output channel
//   S                    : source index of the flit in Out_data
//   Cnt0, Cnt1           : tail-flit counts per input (only with
//                          MERGE7_PKT_COUNT_EN defined)
// Whole packets are kept together: the first flit of a multi-flit packet
// locks the winning input until its tail flit is accepted. Round-robin
// priority flips to the other input after every completed packet.
module merge7_leaf_arbiter
  import merge7_pkg::*;
#(
  parameter int W          = FLIT_W,
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] In0_data,
  input  logic         In0_valid,
  output logic         In0_ready,
  input  logic [W-1:0] In1_data,
  input  logic         In1_valid,
  output logic         In1_ready,
  output logic [W-1:0] Out_data,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic         S
`ifdef MERGE7_PKT_COUNT_EN
  ,
  output logic [15:0]  Cnt0,
  output logic [15:0]  Cnt1
`endif
);

  state_e       state_q, state_d;
  logic         prio_q, prio_d;
  logic         load_ok, gnt, locked, hs, sel_tail;
  logic [W-1:0] sel_data;

  assign locked = (state_q != ST_IDLE);

  // In IDLE a lone requester wins outright; on contention prio decides.
  always_comb begin
    gnt = 1'b0;
    case (state_q)
      ST_LOCK0: gnt = 1'b0;
      ST_LOCK1: gnt = 1'b1;
      default:  gnt = (In0_valid & In1_valid) ? prio_q : In1_valid;
    endcase
  end

  // While locked the owner sees ready even during a bubble; in IDLE ready
  // is only offered to a requesting input. Nothing here looks at data.
  assign In0_ready = _RESET & load_ok & ~gnt & (locked | In0_valid);
  assign In1_ready = _RESET & load_ok &  gnt & (locked | In1_valid);

  assign hs       = (In0_valid & In0_ready) | (In1_valid & In1_ready);
  assign sel_data = gnt ? In1_data : In0_data;
  assign sel_tail = sel_data[W-1];

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (hs) begin
      if (sel_tail) begin
        state_d = ST_IDLE;
        prio_d  = ~gnt;
      end else begin
        state_d = gnt ? ST_LOCK1 : ST_LOCK0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      state_q <= ST_IDLE;
      prio_q  <= PRIO_RESET;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  merge7_out_reg #(.W(W)) u_out (
    .clk_i     (CLK),
    .rst_ni    (_RESET),
    .load_i    (hs),
    .data_i    (sel_data),
    .src_i     (gnt),
    .ready_i   (Out_ready),
    .load_ok_o (load_ok),
    .data_o    (Out_data),
    .src_o     (S),
    .valid_o   (Out_valid)
  );

`ifdef MERGE7_PKT_COUNT_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (hs && sel_tail) begin
      if (gnt) cnt1_d = sat_inc16(cnt1_q);
      else     cnt0_d = sat_inc16(cnt0_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign Cnt0 = cnt0_q;
  assign Cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_merge7_leaf_arbiter.sv
// Bench for merge7_leaf_arbiter: directed scenarios then random traffic,
// all compared against a cycle-level reference model of the merge rules.
module tb_merge7_leaf_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] in0_d, in1_d, out_d;
  logic       in0_v, in0_r, in1_v, in1_r, out_v, out_r, s;
`ifdef MERGE7_PKT_COUNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  merge7_leaf_arbiter dut (
    .CLK(clk), ._RESET(rst_n),
    .In0_data(in0_d), .In0_valid(in0_v), .In0_ready(in0_r),
    .In1_data(in1_d), .In1_valid(in1_v), .In1_ready(in1_r),
    .Out_data(out_d), .Out_valid(out_v), .Out_ready(out_r), .S(s)
`ifdef MERGE7_PKT_COUNT_EN
    , .Cnt0(cnt0), .Cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Source queues: entries >= 0 are flits, -1 is a one-cycle bubble.
  int q0[$], q1[$];
  int log_d[$], log_s[$];
  bit rand_mode = 0;

  // Reference model state: packet owner (-1 = none) and round-robin prio.
  int owner, prio, cand;
  bit m_vld, m_s, e0, e1, m_hs, d_hs0, d_hs1;
  logic [8:0] m_data, m_in;
  int cnt[2];

  task automatic model_reset();
    owner = -1; prio = 0; m_vld = 0; m_s = 0; m_data = '0;
    cnt[0] = 0; cnt[1] = 0;
  endtask

  task automatic push_rand(inout int q[$]);
    int nb, len;
    nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
    len = $urandom_range(1, 3);
    for (int i = 0; i < nb; i++) q.push_back(-1);
    for (int i = 0; i < len; i++)
      q.push_back($urandom_range(0, 255) + ((i == len - 1) ? 256 : 0));
  endtask

  task automatic drive();
    int t;
    if (rand_mode && q0.size() == 0) push_rand(q0);
    if (rand_mode && q1.size() == 0) push_rand(q1);
    in0_v = (q0.size() > 0) && (q0[0] >= 0);
    in1_v = (q1.size() > 0) && (q1[0] >= 0);
    if (in0_v) begin t = q0[0]; in0_d = t[8:0]; end
    if (in1_v) begin t = q1[0]; in1_d = t[8:0]; end
  endtask

  // One clock: drive, check readies mid-cycle, advance model, check outputs.
  task automatic cycle();
    bit lo;
    drive();
    @(negedge clk);
    lo = !m_vld || out_r;
    if (owner >= 0) cand = owner;
    else if (in0_v && in1_v) cand = prio;
    else if (in0_v) cand = 0;
    else if (in1_v) cand = 1;
    else cand = -1;
    e0 = rst_n && lo && cand == 0 && (owner >= 0 || in0_v);
    e1 = rst_n && lo && cand == 1 && (owner >= 0 || in1_v);
    chk("in0_ready", in0_r, e0);
    chk("in1_ready", in1_r, e1);
    m_hs  = (e0 && in0_v) || (e1 && in1_v);
    m_in  = (cand == 1) ? in1_d : in0_d;
    d_hs0 = in0_v && in0_r;
    d_hs1 = in1_v && in1_r;
    if (out_v && out_r) begin log_d.push_back(out_d); log_s.push_back(s); end
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (m_hs) begin
      m_vld = 1; m_data = m_in; m_s = (cand == 1);
      if (m_in[8]) begin
        owner = -1; prio = 1 - cand;
        if (cnt[cand] < 65535) cnt[cand]++;
      end else owner = cand;
    end else if (out_r) m_vld = 0;
    if (q0.size() > 0 && (d_hs0 || q0[0] < 0)) void'(q0.pop_front());
    if (q1.size() > 0 && (d_hs1 || q1[0] < 0)) void'(q1.pop_front());
    #1;
    chk("out_valid", out_v, m_vld);
    chk("out_data", out_d, m_data);
    chk("s", s, m_s);
`ifdef MERGE7_PKT_COUNT_EN
    chk("cnt0", cnt0, cnt[0]);
    chk("cnt1", cnt1, cnt[1]);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q0.size() > 0 || q1.size() > 0 || out_v); i++) cycle();
    chk("drain_done", (q0.size() > 0 || q1.size() > 0 || out_v), 0);
  endtask

  task automatic chk_log(input string tag, input int ed[$], input int es[$]);
    chk({tag, "_len"}, log_d.size(), ed.size());
    for (int i = 0; i < ed.size() && i < log_d.size(); i++) begin
      chk({tag, "_data"}, log_d[i], ed[i]);
      chk({tag, "_s"}, log_s[i], es[i]);
    end
    log_d.delete(); log_s.delete();
  endtask

  initial begin
    int ed[$], es[$];
    model_reset();
    rst_n = 0; out_r = 1; in0_d = '0; in1_d = '0; in0_v = 0; in1_v = 0;

    // Reset with both inputs valid, then single-flit contention.
    for (int i = 0; i < 8; i++) begin q0.push_back('h101); q1.push_back('h1FE); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_out_valid", out_v, 0);
      chk("rst_s", s, 0);
      chk("rst_rdy0", in0_r, 0);
      chk("rst_rdy1", in1_r, 0);
    end
    rst_n = 1;
    cycle();
    chk("first_grant_s", s, 0);
    chk("first_grant_data", out_d, 'h101);
    drain();
    ed.delete(); es.delete();
    for (int i = 0; i < 8; i++) begin
      ed.push_back('h101); es.push_back(0); ed.push_back('h1FE); es.push_back(1);
    end
    chk_log("contend", ed, es);

    // Packet lock: In1 must wait for In0's whole 3-flit packet.
    q0 = '{'h011, 'h022, 'h133}; q1 = '{'h1AA};
    drain();
    ed = '{'h011, 'h022, 'h133, 'h1AA}; es = '{0, 0, 0, 1};
    chk_log("lock", ed, es);

    // Backpressure: output held 4 cycles, nothing lost or duplicated.
    q0 = '{'h144, 'h155}; q1 = '{'h1BB};
    cycle();
    out_r = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("bp_data", out_d, 'h144);
      chk("bp_s", s, 0);
      chk("bp_rdy0", in0_r, 0);
      chk("bp_rdy1", in1_r, 0);
    end
    out_r = 1;
    drain();
    ed = '{'h144, 'h1BB, 'h155}; es = '{0, 1, 0};
    chk_log("bp", ed, es);

    // Mid-packet bubble on the locked input keeps In0 out.
    q1 = '{'h055, -1, -1, 'h166}; q0 = '{'h1AB};
    drain();
    ed = '{'h055, 'h166, 'h1AB}; es = '{1, 1, 0};
    chk_log("bubble", ed, es);

    // Reset in the middle of an In0 packet.
    q0 = '{'h011, 'h022, 'h133};
    cycle();
    rst_n = 0; q0.delete(); q1.delete();
    cycle();
    chk("midrst_out_valid", out_v, 0);
    chk("midrst_s", s, 0);
`ifdef MERGE7_PKT_COUNT_EN
    chk("midrst_cnt0", cnt0, 0);
`endif
    rst_n = 1;
    cycle();
    chk("midrst_idle", out_v, 0);
    log_d.delete(); log_s.delete();

    // Random traffic with random backpressure.
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      out_r = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rand_mode = 0; out_r = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
